// File: rtl/punc_mem_arbiter_if.sv
// Request/grant bus between the PUnC requesters and the memory arbiter,
// plus the memory-side port driven by the arbiter.
interface punc_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Requester side: index 0 = fetch, 1 = load/store, 2 = debug
    logic [2:0]          req;
    logic [2:0]          req_we;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_wdata;
    logic [2:0]          gnt;
    logic [2:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                busy;

    // Memory side
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    // Arbiter view
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rsp_valid, rsp_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester/memory view
    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rsp_valid, rsp_rdata, busy,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the PUnC unified memory.
// Three requesters share one single-port memory with a fixed read latency.
// Each access runs IDLE/RESP (arbitrate) -> ISSUE -> WAIT x MEM_LAT -> RESP.
module punc_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1     // legal 1..7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    punc_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t            state_q;
    logic [1:0]        last_q;
    logic [1:0]        win_q;
    logic              we_q;
    logic [2:0]        cnt_q;
    logic [2:0]        gnt_q;
    logic [2:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    // Unpacked per-requester views of the packed address/data buses
    logic [ADDR_W-1:0] addr_a  [3];
    logic [DATA_W-1:0] wdata_a [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign addr_a[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_a[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
    end

    logic       win_valid_d;
    logic [1:0] win_d;
    logic [1:0] ord0, ord1, ord2;

    // Round-robin pick: search starts one past the most recent grant
    always_comb begin
        case (last_q)
            2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        win_valid_d = 1'b1;
        if (bus.req[ord0])      win_d = ord0;
        else if (bus.req[ord1]) win_d = ord1;
        else if (bus.req[ord2]) win_d = ord2;
        else begin
            win_d       = 2'd0;
            win_valid_d = 1'b0;
        end
    end

    // Sequencer FSM; every bus output is a registered copy of state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_q      <= 2'd2;
            win_q       <= 2'd0;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            gnt_q       <= 3'd0;
            rsp_valid_q <= 3'd0;
            rsp_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Strobes are single-cycle pulses unless set below
            gnt_q       <= 3'd0;
            rsp_valid_q <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (win_valid_d) begin
                        // Latch the winner's command; it drives memory in ISSUE
                        win_q       <= win_d;
                        last_q      <= win_d;
                        we_q        <= bus.req_we[win_d];
                        mem_addr_q  <= addr_a[win_d];
                        mem_wdata_q <= wdata_a[win_d];
                        gnt_q       <= 3'b001 << win_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.req_we[win_d];
                        state_q     <= ISSUE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        // Read data is valid during this last WAIT cycle
                        if (!we_q) begin
                            rsp_rdata_q <= bus.mem_rdata;
                        end
                        rsp_valid_q <= 3'b001 << win_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Testbench for punc_mem_arbiter: three DUTs with MEM_LAT = 1, 2, 4, each
// behind a latency-accurate memory model. Expected responses go into a
// scoreboard queue when a request is driven and are popped on rsp_valid.
`timescale 1ns/1ps
module tb_punc_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-instance stimulus and observation (instance 0: LAT1, 1: LAT2, 2: LAT4)
    logic [2:0]  t_req   [3];
    logic [2:0]  t_we    [3];
    logic [47:0] t_addr  [3];
    logic [47:0] t_wdata [3];
    logic [2:0]  o_gnt   [3];
    logic [2:0]  o_rsp   [3];
    logic [15:0] o_rdata [3];
    logic [15:0] o_maddr [3];
    logic [15:0] o_mwdata[3];
    logic        o_busy  [3];
    logic        o_men   [3];
    logic        o_mwe   [3];

    typedef struct {
        int         inst;
        logic [2:0] id;
        logic [15:0] data;
    } exp_t;
    exp_t sbq[$];

    // Memory contents before any write
    function automatic logic [15:0] memval(input logic [15:0] a);
        if (a[7:0] == 8'h00) return 16'h1234;
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic exp_t mk_exp(input int inst, input logic [2:0] id, input logic [15:0] d);
        exp_t e;
        e.inst = inst;
        e.id   = id;
        e.data = d;
        return e;
    endfunction

    function automatic int oh2id(input logic [2:0] oh);
        case (oh)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 3;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;

        punc_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

        punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );

        // Memory model: writes overlay the default contents; reads come back LAT cycles after mem_en
        logic [255:0] wr_v = '0;
        logic [15:0]  wr_d [256];
        logic [15:0]  pipe [8];
        logic [15:0]  rd_val;

        assign rd_val = wr_v[bus.mem_addr[7:0]] ? wr_d[bus.mem_addr[7:0]] : memval(bus.mem_addr);

        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_we) begin
                wr_v[bus.mem_addr[7:0]] <= 1'b1;
                wr_d[bus.mem_addr[7:0]] <= bus.mem_wdata;
            end
            pipe[0] <= (bus.mem_en && !bus.mem_we) ? rd_val : 16'hDEAD;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end

        assign bus.mem_rdata = pipe[LAT-1];
        assign bus.req       = t_req[gi];
        assign bus.req_we    = t_we[gi];
        assign bus.req_addr  = t_addr[gi];
        assign bus.req_wdata = t_wdata[gi];
        assign o_gnt[gi]     = bus.gnt;
        assign o_rsp[gi]     = bus.rsp_valid;
        assign o_rdata[gi]   = bus.rsp_rdata;
        assign o_maddr[gi]   = bus.mem_addr;
        assign o_mwdata[gi]  = bus.mem_wdata;
        assign o_busy[gi]    = bus.busy;
        assign o_men[gi]     = bus.mem_en;
        assign o_mwe[gi]     = bus.mem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until rsp_valid on the instance; n = cycles waited, -1 on timeout
    task automatic wait_rsp(input int inst, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (o_rsp[inst] == 3'd0 && n < 30);
        if (o_rsp[inst] == 3'd0) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (o_gnt[i] !== 3'd0 || o_rsp[i] !== 3'd0 || o_men[i] !== 1'b0 || o_mwe[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_strobes inst%0d: gnt=%b rsp=%b en=%b we=%b, expected all 0",
                         i, o_gnt[i], o_rsp[i], o_men[i], o_mwe[i]);
            end
            n_tests++;
            if (o_busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy inst%0d: got %b expected 0", i, o_busy[i]);
            end
            n_tests++;
            if (o_maddr[i] !== 16'h0 || o_mwdata[i] !== 16'h0 || o_rdata[i] !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_data inst%0d: addr=%h wdata=%h rdata=%h expected 0",
                         i, o_maddr[i], o_mwdata[i], o_rdata[i]);
            end
        end
        rst_n = 1'b1;
        tick();
        $display("[TB] reset: checked all instances");
    endtask

    task automatic test_single_read();
        int   n;
        exp_t e;
        t_req[1]   = 3'b001;
        t_we[1]    = 3'b000;
        t_addr[1]  = {16'h0000, 16'h0000, 16'h3000};
        t_wdata[1] = '0;
        sbq.push_back(mk_exp(1, 3'b001, 16'h1234));
        tick();
        n_tests++;
        if (o_gnt[1] !== 3'b001) begin
            n_fail++;
            $display("FAIL read_gnt: got %b expected 001", o_gnt[1]);
        end
        n_tests++;
        if (o_men[1] !== 1'b1 || o_mwe[1] !== 1'b0 || o_maddr[1] !== 16'h3000) begin
            n_fail++;
            $display("FAIL read_issue: en=%b we=%b addr=%h expected 1/0/3000", o_men[1], o_mwe[1], o_maddr[1]);
        end
        t_req[1] = 3'b000;
        wait_rsp(1, n);
        e = sbq.pop_front();
        n_tests++;
        if (n !== 3) begin
            n_fail++;
            $display("FAIL read_latency: rsp %0d cycles after ISSUE, expected 3", n);
        end
        n_tests++;
        if (o_rsp[1] !== e.id || o_rdata[1] !== e.data) begin
            n_fail++;
            $display("FAIL read_rsp: rsp=%b data=%h expected %b/%h", o_rsp[1], o_rdata[1], e.id, e.data);
        end
        $display("[TB] single_read: addr=3000 rsp=%b data=%h after %0d cycles", o_rsp[1], o_rdata[1], n);
    endtask

    // Read to set rsp_rdata, write that must leave it alone, read back the write
    task automatic test_write();
        logic [15:0] tw_addr [3] = '{16'h0005, 16'h4000, 16'h4000};
        logic [15:0] tw_data [3] = '{16'h0000, 16'hBEEF, 16'h0000};
        logic        tw_we   [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] tw_exp  [3] = '{16'h05FA, 16'h05FA, 16'hBEEF};
        int   n;
        exp_t e;
        for (int j = 0; j < 3; j++) begin
            t_req[0]   = 3'b010;
            t_we[0]    = {1'b0, tw_we[j], 1'b0};
            t_addr[0]  = {16'h0000, tw_addr[j], 16'h0000};
            t_wdata[0] = {16'h0000, tw_data[j], 16'h0000};
            sbq.push_back(mk_exp(0, 3'b010, tw_exp[j]));
            tick();
            n_tests++;
            if (o_gnt[0] !== 3'b010 || o_men[0] !== 1'b1 || o_mwe[0] !== tw_we[j]) begin
                n_fail++;
                $display("FAIL wr_issue[%0d]: gnt=%b en=%b we=%b expected 010/1/%b",
                         j, o_gnt[0], o_men[0], o_mwe[0], tw_we[j]);
            end
            n_tests++;
            if (o_maddr[0] !== tw_addr[j] || (tw_we[j] && o_mwdata[0] !== tw_data[j])) begin
                n_fail++;
                $display("FAIL wr_bus[%0d]: addr=%h wdata=%h expected %h/%h",
                         j, o_maddr[0], o_mwdata[0], tw_addr[j], tw_data[j]);
            end
            t_req[0] = 3'b000;
            wait_rsp(0, n);
            e = sbq.pop_front();
            n_tests++;
            if (n !== 2) begin
                n_fail++;
                $display("FAIL wr_latency[%0d]: rsp %0d cycles after ISSUE, expected 2", j, n);
            end
            n_tests++;
            if (o_rsp[0] !== e.id || o_rdata[0] !== e.data) begin
                n_fail++;
                $display("FAIL wr_rsp[%0d]: rsp=%b data=%h expected %b/%h", j, o_rsp[0], o_rdata[0], e.id, e.data);
            end
            $display("[TB] write_seq[%0d]: we=%b addr=%h rsp=%b data=%h", j, tw_we[j], tw_addr[j], o_rsp[0], o_rdata[0]);
        end
    endtask

    task automatic test_simultaneous();
        int   g_ids[$];
        int   g_cyc[$];
        int   nrsp = 0;
        exp_t e;
        rst_n      = 1'b0;
        t_req[1]   = 3'b111;
        t_we[1]    = 3'b000;
        t_addr[1]  = {16'h0032, 16'h0021, 16'h0010};
        sbq.push_back(mk_exp(1, 3'b001, memval(16'h0010)));
        sbq.push_back(mk_exp(1, 3'b010, memval(16'h0021)));
        sbq.push_back(mk_exp(1, 3'b100, memval(16'h0032)));
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 40 && (g_ids.size() < 3 || nrsp < 3); c++) begin
            tick();
            if (o_gnt[1] != 3'd0) begin
                g_ids.push_back(oh2id(o_gnt[1]));
                g_cyc.push_back(c);
                t_req[1] = t_req[1] & ~o_gnt[1];
                $display("[TB] simultaneous: grant %b at cycle %0d", o_gnt[1], c);
            end
            if (o_rsp[1] != 3'd0) begin
                nrsp++;
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL sim_rsp: unexpected rsp=%b", o_rsp[1]);
                end else begin
                    e = sbq.pop_front();
                    if (o_rsp[1] !== e.id || o_rdata[1] !== e.data) begin
                        n_fail++;
                        $display("FAIL sim_rsp: rsp=%b data=%h expected %b/%h", o_rsp[1], o_rdata[1], e.id, e.data);
                    end
                end
            end
        end
        t_req[1] = 3'b000;
        n_tests++;
        if (g_ids.size() != 3 || nrsp != 3) begin
            n_fail++;
            $display("FAIL sim_count: grants=%0d rsps=%0d expected 3/3", g_ids.size(), nrsp);
        end else begin
            n_tests++;
            if (g_ids[0] != 0 || g_ids[1] != 1 || g_ids[2] != 2) begin
                n_fail++;
                $display("FAIL sim_order: got %0d,%0d,%0d expected 0,1,2", g_ids[0], g_ids[1], g_ids[2]);
            end
            n_tests++;
            if (g_cyc[1] - g_cyc[0] != 4 || g_cyc[2] - g_cyc[1] != 4) begin
                n_fail++;
                $display("FAIL sim_spacing: gaps %0d,%0d expected 4,4", g_cyc[1] - g_cyc[0], g_cyc[2] - g_cyc[1]);
            end
        end
    endtask

    task automatic test_fairness();
        int   g_ids[$];
        int   nrsp = 0;
        exp_t e;
        t_we[1]   = 3'b000;
        t_addr[1] = {16'h0000, 16'h0051, 16'h0040};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) sbq.push_back(mk_exp(1, 3'b001, memval(16'h0040)));
            else            sbq.push_back(mk_exp(1, 3'b010, memval(16'h0051)));
        end
        t_req[1] = 3'b011;
        for (int c = 1; c <= 60 && (g_ids.size() < 4 || nrsp < 4); c++) begin
            tick();
            if (o_gnt[1] != 3'd0) begin
                g_ids.push_back(oh2id(o_gnt[1]));
                if (g_ids.size() == 4) t_req[1] = 3'b000;
                $display("[TB] fairness: grant %b at cycle %0d", o_gnt[1], c);
            end
            if (o_rsp[1] != 3'd0) begin
                nrsp++;
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL fair_rsp: unexpected rsp=%b", o_rsp[1]);
                end else begin
                    e = sbq.pop_front();
                    if (o_rsp[1] !== e.id || o_rdata[1] !== e.data) begin
                        n_fail++;
                        $display("FAIL fair_rsp: rsp=%b data=%h expected %b/%h", o_rsp[1], o_rdata[1], e.id, e.data);
                    end
                end
            end
        end
        t_req[1] = 3'b000;
        n_tests++;
        if (g_ids.size() != 4) begin
            n_fail++;
            $display("FAIL fair_count: grants=%0d expected 4", g_ids.size());
        end else if (g_ids[0] != 0 || g_ids[1] != 1 || g_ids[2] != 0 || g_ids[3] != 1) begin
            n_fail++;
            $display("FAIL fair_order: got %0d,%0d,%0d,%0d expected 0,1,0,1", g_ids[0], g_ids[1], g_ids[2], g_ids[3]);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int   bad = 0;
        int   n;
        exp_t e;
        t_req[2]  = 3'b010;
        t_we[2]   = 3'b000;
        t_addr[2] = {16'h0000, 16'h0077, 16'h0000};
        tick();
        n_tests++;
        if (o_gnt[2] !== 3'b010) begin
            n_fail++;
            $display("FAIL rmw_gnt: got %b expected 010", o_gnt[2]);
        end
        t_req[2] = 3'b000;
        tick();   // first WAIT cycle
        tick();   // second WAIT cycle
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_gnt[2] !== 3'd0 || o_rsp[2] !== 3'd0 || o_men[2] !== 1'b0 || o_mwe[2] !== 1'b0 ||
            o_busy[2] !== 1'b0 || o_maddr[2] !== 16'h0 || o_mwdata[2] !== 16'h0 || o_rdata[2] !== 16'h0) begin
            n_fail++;
            $display("FAIL rmw_async: busy=%b addr=%h rdata=%h en=%b expected all 0",
                     o_busy[2], o_maddr[2], o_rdata[2], o_men[2]);
        end
        tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            if (o_busy[2] !== 1'b0 || o_rsp[2] !== 3'd0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rmw_dropped: %0d cycles with busy or rsp_valid set, expected 0", bad);
        end
        t_req[2]  = 3'b101;
        t_addr[2] = {16'h0099, 16'h0000, 16'h0088};
        sbq.push_back(mk_exp(2, 3'b001, memval(16'h0088)));
        tick();
        n_tests++;
        if (o_gnt[2] !== 3'b001) begin
            n_fail++;
            $display("FAIL rmw_order: got %b expected 001", o_gnt[2]);
        end
        t_req[2] = 3'b000;
        wait_rsp(2, n);
        e = sbq.pop_front();
        n_tests++;
        if (n !== 5 || o_rsp[2] !== e.id || o_rdata[2] !== e.data) begin
            n_fail++;
            $display("FAIL rmw_rsp: n=%0d rsp=%b data=%h expected 5/%b/%h", n, o_rsp[2], o_rdata[2], e.id, e.data);
        end
        $display("[TB] reset_mid_wait: post-reset grant served, data=%h", o_rdata[2]);
        tick();
    endtask

    task automatic test_idle_hold();
        int bad [3] = '{0, 0, 0};
        for (int i = 0; i < 3; i++) t_req[i] = 3'b000;
        repeat (10) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (o_busy[i] !== 1'b0 || o_men[i] !== 1'b0 || o_gnt[i] !== 3'd0 || o_rsp[i] !== 3'd0) bad[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bad[i] != 0) begin
                n_fail++;
                $display("FAIL idle_hold inst%0d: %0d active cycles, expected 0", i, bad[i]);
            end
        end
        $display("[TB] idle_hold: 10 cycles observed");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            t_req[i]   = 3'b000;
            t_we[i]    = 3'b000;
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        test_reset();
        test_single_read();
        test_write();
        test_simultaneous();
        test_fairness();
        test_reset_mid_wait();
        test_idle_hold();
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
